// File: rtl/dla_noc_packetizer_pkg.sv
// rtl/dla_noc_packetizer_pkg.sv - NoC flit geometry, labels and head-field layout shared with the router-side bridge
package dla_noc_packetizer_pkg;

  localparam int FLIT_DATA_SIZE   = 32;
  localparam int FLIT_LABEL_SIZE  = 2;
  localparam int FLIT_TOTAL_SIZE  = FLIT_LABEL_SIZE + FLIT_DATA_SIZE;
  localparam int DEST_ADDR_SIZE_X = 4;
  localparam int DEST_ADDR_SIZE_Y = 4;
  localparam int DEST_ADDR_SIZE_L = 3;
  localparam int GRANT_PL_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + 2;

  typedef enum logic [FLIT_LABEL_SIZE-1:0] {
    FLIT_HEAD     = 2'd0,
    FLIT_BODY     = 2'd1,
    FLIT_TAIL     = 2'd2,
    FLIT_HEADTAIL = 2'd3
  } flit_label_t;

  // Low-order field first in the flit: l_dest occupies bit 0 upward.
  typedef struct packed {
    logic [GRANT_PL_SIZE-1:0]    head_pl;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
    logic [DEST_ADDR_SIZE_L-1:0] l_dest;
  } head_field_t;

  localparam int HEAD_FIELD_SIZE = $bits(head_field_t);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } pkt_state_t;

  function automatic logic [FLIT_TOTAL_SIZE-1:0] make_head_flit(input flit_label_t label,
                                                                 input head_field_t hf);
    return {label, {(FLIT_DATA_SIZE-HEAD_FIELD_SIZE){1'b0}}, hf};
  endfunction

endpackage

// File: rtl/dla_noc_packetizer.sv
// rtl/dla_noc_packetizer.sv - DLA-side NoC flit builder feeding the async FIFO write port
// Grant (HEADTAIL) path present only when DLA_NOC_PKT_GRANT_EN is defined.
module dla_noc_packetizer
  import dla_noc_packetizer_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                        clk_dla,
  input  logic                        rst_dla,
  input  logic                        req_vld,
  output logic                        req_rdy,
  input  logic [DEST_ADDR_SIZE_X-1:0] req_dest_x,
  input  logic [DEST_ADDR_SIZE_Y-1:0] req_dest_y,
  input  logic [DEST_ADDR_SIZE_L-1:0] req_dest_l,
  input  logic [LEN_W-1:0]            req_len,
  input  logic                        data_vld,
  output logic                        data_rdy,
  input  logic [FLIT_DATA_SIZE-1:0]   data,
  input  logic                        grnt_vld,
  output logic                        grnt_rdy,
  input  logic [DEST_ADDR_SIZE_X-1:0] grnt_dest_x,
  input  logic [DEST_ADDR_SIZE_Y-1:0] grnt_dest_y,
  input  logic [DEST_ADDR_SIZE_L-1:0] grnt_dest_l,
  input  logic [GRANT_PL_SIZE-1:0]    grnt_pl,
  input  logic                        wbuf_full,
  output logic                        wbuf_wen,
  output logic [FLIT_TOTAL_SIZE-1:0]  wbuf_wdata,
  output logic                        busy,
  output logic [CNT_W-1:0]            pkts_sent
);

  pkt_state_t       state_q, state_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] pkts_q, pkts_d;

`ifdef DLA_NOC_PKT_GRANT_EN
  logic grant_last_q, grant_last_d;
  logic pick_grant;

  assign pick_grant = grnt_vld && (!req_vld || !grant_last_q);
`else
  wire unused_grnt = ^{grnt_vld, grnt_dest_x, grnt_dest_y, grnt_dest_l, grnt_pl};
`endif

  always_ff @(posedge clk_dla or posedge rst_dla) begin
    if (rst_dla) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      pkts_q       <= '0;
`ifdef DLA_NOC_PKT_GRANT_EN
      grant_last_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      pkts_q       <= pkts_d;
`ifdef DLA_NOC_PKT_GRANT_EN
      grant_last_q <= grant_last_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    pkts_d       = pkts_q;
    req_rdy      = 1'b0;
    data_rdy     = 1'b0;
    grnt_rdy     = 1'b0;
    wbuf_wen     = 1'b0;
    wbuf_wdata   = '0;
`ifdef DLA_NOC_PKT_GRANT_EN
    grant_last_d = grant_last_q;
`endif
    // Handshakes are combinational, so gate them off while reset is held.
    if (!rst_dla) begin
      unique case (state_q)
        ST_IDLE: begin
`ifdef DLA_NOC_PKT_GRANT_EN
          if (!wbuf_full && pick_grant) begin
            grnt_rdy     = 1'b1;
            wbuf_wen     = 1'b1;
            wbuf_wdata   = make_head_flit(FLIT_HEADTAIL,
                                          '{head_pl: grnt_pl, x_dest: grnt_dest_x,
                                            y_dest: grnt_dest_y, l_dest: grnt_dest_l});
            grant_last_d = 1'b1;
            pkts_d       = pkts_q + CNT_W'(1);
          end else
`endif
          if (!wbuf_full && req_vld) begin
            req_rdy    = 1'b1;
            wbuf_wen   = 1'b1;
            wbuf_wdata = make_head_flit(FLIT_HEAD,
                                        '{head_pl: '0, x_dest: req_dest_x,
                                          y_dest: req_dest_y, l_dest: req_dest_l});
            beat_cnt_d = req_len;
`ifdef DLA_NOC_PKT_GRANT_EN
            grant_last_d = 1'b0;
`endif
            state_d    = ST_BODY;
          end
        end
        ST_BODY: begin
          data_rdy = !wbuf_full;
          if (data_vld && !wbuf_full) begin
            wbuf_wen = 1'b1;
            if (beat_cnt_q == '0) begin
              wbuf_wdata = {FLIT_TAIL, data};
              pkts_d     = pkts_q + CNT_W'(1);
              state_d    = ST_IDLE;
            end else begin
              wbuf_wdata = {FLIT_BODY, data};
              beat_cnt_d = beat_cnt_q - LEN_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == ST_BODY);
  assign pkts_sent = pkts_q;

endmodule

// File: tb/tb_dla_noc_packetizer.sv
// tb/tb_dla_noc_packetizer.sv - scoreboard bench for dla_noc_packetizer (grant cases need DLA_NOC_PKT_GRANT_EN)
module tb_dla_noc_packetizer;
  import dla_noc_packetizer_pkg::*;

  localparam int LEN_W = 8;
  localparam int CNT_W = 10;  // narrowed so the counter wrap is reachable in a short run

  logic                        clk_dla = 1'b0;
  logic                        rst_dla;
  logic                        req_vld, req_rdy;
  logic [DEST_ADDR_SIZE_X-1:0] req_dest_x;
  logic [DEST_ADDR_SIZE_Y-1:0] req_dest_y;
  logic [DEST_ADDR_SIZE_L-1:0] req_dest_l;
  logic [LEN_W-1:0]            req_len;
  logic                        data_vld, data_rdy;
  logic [FLIT_DATA_SIZE-1:0]   data;
  logic                        grnt_vld, grnt_rdy;
  logic [DEST_ADDR_SIZE_X-1:0] grnt_dest_x;
  logic [DEST_ADDR_SIZE_Y-1:0] grnt_dest_y;
  logic [DEST_ADDR_SIZE_L-1:0] grnt_dest_l;
  logic [GRANT_PL_SIZE-1:0]    grnt_pl;
  logic                        wbuf_full, wbuf_wen;
  logic [FLIT_TOTAL_SIZE-1:0]  wbuf_wdata;
  logic                        busy;
  logic [CNT_W-1:0]            pkts_sent;

  int checks   = 0;
  int failures = 0;
  int exp_pkts = 0;
  logic [FLIT_TOTAL_SIZE-1:0] sb[$];

  dla_noc_packetizer #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk_dla(clk_dla), .rst_dla(rst_dla),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_dest_x(req_dest_x), .req_dest_y(req_dest_y), .req_dest_l(req_dest_l),
    .req_len(req_len),
    .data_vld(data_vld), .data_rdy(data_rdy), .data(data),
    .grnt_vld(grnt_vld), .grnt_rdy(grnt_rdy),
    .grnt_dest_x(grnt_dest_x), .grnt_dest_y(grnt_dest_y), .grnt_dest_l(grnt_dest_l),
    .grnt_pl(grnt_pl),
    .wbuf_full(wbuf_full), .wbuf_wen(wbuf_wen), .wbuf_wdata(wbuf_wdata),
    .busy(busy), .pkts_sent(pkts_sent)
  );

  always #5 clk_dla = ~clk_dla;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [FLIT_TOTAL_SIZE-1:0] exp_head(input flit_label_t lab,
      input logic [3:0] x, input logic [3:0] y, input logic [2:0] l, input logic [9:0] pl);
    logic [FLIT_TOTAL_SIZE-1:0] f;
    f        = '0;
    f[2:0]   = l;
    f[6:3]   = y;
    f[10:7]  = x;
    f[20:11] = pl;
    f[33:32] = lab;
    return f;
  endfunction

  function automatic logic [FLIT_TOTAL_SIZE-1:0] exp_data(input flit_label_t lab,
                                                          input logic [31:0] d);
    return {lab, d};
  endfunction

  // Scoreboard monitor: every FIFO write must match the oldest expected flit.
  always @(negedge clk_dla) begin
    if (!rst_dla && wbuf_wen) begin
      chk("wen_while_full", {63'd0, wbuf_full}, 64'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_flit actual=%0h required=none", wbuf_wdata);
      end else begin
        chk("flit", {30'd0, wbuf_wdata}, {30'd0, sb.pop_front()});
      end
    end
  end

  // which: 0=req_rdy 1=data_rdy 2=grnt_rdy; returns at the negedge where it is high
  task automatic wait_hs(input int which);
    bit seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk_dla);
      case (which)
        0: seen = req_rdy;
        1: seen = data_rdy;
        default: seen = grnt_rdy;
      endcase
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout actual=0 required=1 (which=%0d)", which);
    end
  endtask

  task automatic do_req(input logic [3:0] x, input logic [3:0] y, input logic [2:0] l,
                        input logic [7:0] len, input logic [31:0] base,
                        input int n_beats, input int stall_at, input bit push);
    if (push) sb.push_back(exp_head(FLIT_HEAD, x, y, l, 10'd0));
    req_dest_x = x; req_dest_y = y; req_dest_l = l; req_len = len;
    req_vld = 1'b1;
    wait_hs(0);
    @(posedge clk_dla); #1;
    req_vld = 1'b0;
    for (int i = 0; i < n_beats; i++) begin
      data = base + 32'(i);
      data_vld = 1'b1;
      if (push) sb.push_back(exp_data((i == int'(len)) ? FLIT_TAIL : FLIT_BODY, data));
      if (i == stall_at) begin
        wbuf_full = 1'b1;
        repeat (5) begin
          @(negedge clk_dla);
          chk("stall_data_rdy", {63'd0, data_rdy}, 64'd0);
          chk("stall_wen", {63'd0, wbuf_wen}, 64'd0);
        end
        @(posedge clk_dla); #1;
        wbuf_full = 1'b0;
      end
      wait_hs(1);
      @(posedge clk_dla); #1;
      data_vld = 1'b0;
    end
  endtask

  initial begin
    rst_dla = 1'b1;
    req_vld = 1'b1; req_dest_x = '0; req_dest_y = '0; req_dest_l = '0; req_len = '0;
    data_vld = 1'b1; data = '0;
    grnt_vld = 1'b1; grnt_dest_x = '0; grnt_dest_y = '0; grnt_dest_l = '0; grnt_pl = '0;
    wbuf_full = 1'b0;
    repeat (3) @(posedge clk_dla);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_pkts", {54'd0, pkts_sent}, 64'd0);
    chk("rst_wen", {63'd0, wbuf_wen}, 64'd0);
    chk("rst_req_rdy", {63'd0, req_rdy}, 64'd0);
    chk("rst_grnt_rdy", {63'd0, grnt_rdy}, 64'd0);
    req_vld = 1'b0; data_vld = 1'b0; grnt_vld = 1'b0;
    @(posedge clk_dla); #1;
    rst_dla = 1'b0;
    @(posedge clk_dla); #1;

    // Basic packet: dest (3,5,2), three payload beats A,B,C.
    do_req(4'd3, 4'd5, 3'd2, 8'd2, 32'hA, 3, -1, 1'b1);
    exp_pkts++;
    chk("basic_pkts", {54'd0, pkts_sent}, 64'(exp_pkts));
    chk("basic_busy", {63'd0, busy}, 64'd0);

`ifdef DLA_NOC_PKT_GRANT_EN
    // Single grant: HEADTAIL with payload {x=2,y=4,dla=3}.
    sb.push_back(exp_head(FLIT_HEADTAIL, 4'd1, 4'd1, 3'd0, {4'd2, 4'd4, 2'd3}));
    grnt_dest_x = 4'd1; grnt_dest_y = 4'd1; grnt_dest_l = 3'd0;
    grnt_pl = {4'd2, 4'd4, 2'd3};
    grnt_vld = 1'b1;
    wait_hs(2);
    chk("grant_busy", {63'd0, busy}, 64'd0);
    @(posedge clk_dla); #1;
    grnt_vld = 1'b0;
    exp_pkts++;
    @(negedge clk_dla);
    chk("grant_rdy_one_cycle", {63'd0, grnt_rdy}, 64'd0);
    chk("grant_pkts", {54'd0, pkts_sent}, 64'(exp_pkts));
    chk("grant_busy_after", {63'd0, busy}, 64'd0);
    @(posedge clk_dla); #1;
`else
    // Without the grant path a grant request is ignored.
    grnt_vld = 1'b1;
    repeat (3) begin
      @(negedge clk_dla);
      chk("grnt_rdy_disabled", {63'd0, grnt_rdy}, 64'd0);
      chk("wen_grant_disabled", {63'd0, wbuf_wen}, 64'd0);
    end
    @(posedge clk_dla); #1;
    grnt_vld = 1'b0;
`endif

    // FIFO full for five cycles mid-BODY, data held by the source.
    do_req(4'd7, 4'd2, 3'd1, 8'd3, 32'h5000_0000, 4, 1, 1'b1);
    exp_pkts++;
    chk("stall_pkts", {54'd0, pkts_sent}, 64'(exp_pkts));

`ifdef DLA_NOC_PKT_GRANT_EN
    // Contention: expected order grant, req, grant, req.
    grnt_dest_x = 4'd6; grnt_dest_y = 4'd9; grnt_dest_l = 3'd4; grnt_pl = 10'h2A5;
    sb.push_back(exp_head(FLIT_HEADTAIL, 4'd6, 4'd9, 3'd4, 10'h2A5));
    sb.push_back(exp_head(FLIT_HEAD, 4'd1, 4'd2, 3'd3, 10'd0));
    sb.push_back(exp_data(FLIT_TAIL, 32'hC0DE_0000));
    sb.push_back(exp_head(FLIT_HEADTAIL, 4'd6, 4'd9, 3'd4, 10'h2A5));
    sb.push_back(exp_head(FLIT_HEAD, 4'd1, 4'd2, 3'd3, 10'd0));
    sb.push_back(exp_data(FLIT_TAIL, 32'hC0DE_0001));
    fork
      begin
        do_req(4'd1, 4'd2, 3'd3, 8'd0, 32'hC0DE_0000, 1, -1, 1'b0);
        do_req(4'd1, 4'd2, 3'd3, 8'd0, 32'hC0DE_0001, 1, -1, 1'b0);
      end
      begin
        grnt_vld = 1'b1;
        repeat (2) begin
          wait_hs(2);
          @(posedge clk_dla); #1;
        end
        grnt_vld = 1'b0;
      end
    join
    exp_pkts += 4;
    chk("contention_pkts", {54'd0, pkts_sent}, 64'(exp_pkts));
    chk("contention_drained", 64'(sb.size()), 64'd0);
`endif

    // Longest packet: 256 payload flits, only the last is TAIL.
    do_req(4'd15, 4'd15, 3'd7, 8'd255, 32'h1000_0000, 256, -1, 1'b1);
    exp_pkts++;
    chk("len255_pkts", {54'd0, pkts_sent}, 64'(exp_pkts));

    // Reset after HEAD and one BODY of a req_len=3 packet.
    do_req(4'd2, 4'd3, 3'd4, 8'd3, 32'hDEAD_0000, 1, -1, 1'b1);
    chk("midpkt_busy", {63'd0, busy}, 64'd1);
    rst_dla = 1'b1;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_pkts", {54'd0, pkts_sent}, 64'd0);
    chk("midrst_wen", {63'd0, wbuf_wen}, 64'd0);
    @(posedge clk_dla); #1;
    rst_dla = 1'b0;
    exp_pkts = 0;
    do_req(4'd4, 4'd4, 3'd5, 8'd0, 32'hFEED_0000, 1, -1, 1'b1);
    exp_pkts++;
    chk("fresh_pkts", {54'd0, pkts_sent}, 64'(exp_pkts));

    // Counter wrap at 2^CNT_W.
    for (int k = 1; k < (1 << CNT_W) - 1; k++)
      do_req(4'd0, 4'd1, 3'd2, 8'd0, 32'(k), 1, -1, 1'b1);
    chk("pkts_max", {54'd0, pkts_sent}, 64'((1 << CNT_W) - 1));
    do_req(4'd0, 4'd1, 3'd2, 8'd0, 32'hFFFF_FFFF, 1, -1, 1'b1);
    chk("pkts_wrap", {54'd0, pkts_sent}, 64'd0);

    repeat (3) @(posedge clk_dla);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
